vpu_cmd_queue: RTL and testbench
================================

Name: vpu_cmd_queue

Overview:
Parametrised command queue and dispatcher between the instruction sequencer and vector_unit. It buffers DEPTH 128-bit vector commands and filters out non-VPU opcodes. Commands are issued to vector_unit over a valid/ready handshake, with in-flight commands capped by cmd_done credits. Barrier (SYNC) commands are executed locally: all earlier commands drain before later ones issue.

Parameters:
CMD_W, 128, command width; opcode at [CMD_W-1:CMD_W-8], subop at [CMD_W-9:CMD_W-16]
DEPTH, 8, FIFO entries; power of two, >=2
MAX_OUT, 4, max commands issued but not yet completed; >=1
VPU_OPCODE, 8'h02, opcode accepted for queueing
SYNC_SUBOP, 8'hFF, subop marking a barrier command

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous; empties FIFO
in_cmd  in  CMD_W  command from sequencer
in_valid  in  1  in_cmd valid
in_ready  out  1  queue can accept
out_cmd  out  CMD_W  command to vector_unit
out_valid  out  1  out_cmd valid
out_ready  in  1  vector_unit cmd_ready
out_done  in  1  vector_unit cmd_done, one pulse per completed command
count  out  $clog2(DEPTH)+1  FIFO occupancy
outstanding  out  $clog2(MAX_OUT)+1  in-flight commands
idle  out  1  FIFO empty, outstanding==0, state ISSUE
sync_done  out  1  one-cycle pulse when a barrier retires
err_opcode  out  1  one-cycle pulse: command dropped for bad opcode
err_done  out  1  sticky: out_done received with outstanding==0

Behaviour:
- Reset:
  - All pointers, counts and error flags are 0.
  - State is ISSUE.
  - out_valid=0, out_cmd=0, in_ready=1, idle=1.
- Input handshake:
  - in_ready = !full && !flush. Transfer on in_valid && in_ready.
  - No pass-through: an accepted command is visible on out_cmd no earlier than the next cycle.
- Opcode filter: a transferred command with opcode != VPU_OPCODE is consumed but not stored. err_opcode pulses the following cycle.
- FIFO: read/write pointers carry an extra wrap bit. full = (addr bits equal, wrap bits differ). Pointers wrap modulo DEPTH.
- Push and pop in the same cycle is legal whenever not full. count is then unchanged.
- Output: out_cmd is the FIFO head (show-ahead). It is held stable while out_valid && !out_ready.
- FSM ISSUE:
  - If the head is a normal command: out_valid = !empty && outstanding<MAX_OUT.
  - Dispatch on out_valid && out_ready: pop, outstanding+1.
  - If the head is a barrier (subop==SYNC_SUBOP): out_valid=0 and go to WAIT_SYNC.
- FSM WAIT_SYNC: when outstanding==0, pop the barrier (never sent to vector_unit), pulse sync_done, return to ISSUE. out_valid=0 throughout.
- Outstanding accounting:
  - dispatch only: +1. out_done only: -1. Both in one cycle: unchanged.
  - out_done with outstanding==0: count stays 0 and err_done sets; cleared only by rst.
- flush:
  - Clears pointers and count, and forces state to ISSUE next cycle.
  - outstanding is not cleared; in-flight completions are still counted.
  - A flush coincident with a dispatch completes the dispatch (outstanding+1), then the FIFO empties.
- rst mid-operation: immediate return to reset values. In-flight vector_unit commands are forgotten; subsequent out_done pulses set err_done.

Optional Feature:
VPU_CMDQ_PERF_EN:
- Defined: adds outputs perf_issued (32b, dispatches), perf_stall (32b, cycles with !empty && !out_valid in ISSUE or any cycle in WAIT_SYNC) and perf_dropped (16b, opcode rejects).
- All three counters saturate at max, and are cleared by rst and by a one-cycle perf_clr input.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package vpu_pkg:
  - field-position localparams OPC_HI/LO, SUBOP_HI/LO, LEN_HI/LO (LEN at [63:48]);
  - VPU_OPCODE and SYNC_SUBOP constants;
  - state enum ISSUE/WAIT_SYNC.
- One natural sub-module: vpu_cmd_fifo (show-ahead FIFO with count, full/empty, flush). The dispatcher FSM and credit counter stay in the top module.

Test Plan:
- Reset then push 3 commands (opcode 02, subops 30/31/32) with out_ready=1 and out_done returned 2 cycles after each dispatch -> out_cmd order 30,31,32; outstanding peaks ≤3; idle=1 at end.
- Push opcode 05 -> in_ready=1, command consumed; err_opcode pulses once; count stays 0; out_valid never asserts.
- out_ready=0, push DEPTH=8 commands -> in_ready=0 after 8th; count=8; out_cmd holds the first command. Simultaneous push and pop at count=7 -> count stays 7.
- MAX_OUT=4, out_ready=1, no out_done, push 6 -> exactly 4 dispatches, out_valid=0. Pulse out_done once -> 5th dispatches.
- Push A, SYNC, B with A outstanding -> B not dispatched until out_done for A. sync_done pulses once; the SYNC command never appears with out_valid=1.
- out_done with outstanding=0 -> err_done=1 sticky. flush with count=5 -> count=0 next cycle, outstanding unchanged. Assert rst mid-stream -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/vpu_pkg.sv
`default_nettype none
// =====================================================================
// Package  : vpu_pkg
// Brief    : Shared command field positions, opcode constants and the
//            dispatcher state encoding for the VPU command path.
// Revision : 1.0 - initial release
// =====================================================================
package vpu_pkg;

    // Field positions for the default 128-bit command word
    localparam int OPC_HI   = 127;
    localparam int OPC_LO   = 120;
    localparam int SUBOP_HI = 119;
    localparam int SUBOP_LO = 112;
    localparam int LEN_HI   = 63;
    localparam int LEN_LO   = 48;

    localparam logic [7:0] VPU_OPCODE = 8'h02;
    localparam logic [7:0] SYNC_SUBOP = 8'hFF;

    typedef enum logic [0:0] {
        ISSUE     = 1'b0,
        WAIT_SYNC = 1'b1
    } cmdq_state_t;

endpackage
`default_nettype wire

// File: rtl/vpu_cmd_fifo.sv
`default_nettype none
// =====================================================================
// Module   : vpu_cmd_fifo
// Brief    : Show-ahead command FIFO with wrap-bit pointers, occupancy
//            count and synchronous flush.
// Revision : 1.0 - initial release
// =====================================================================
module vpu_cmd_fifo #(
    parameter int CMD_W = 128,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [CMD_W-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [CMD_W-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; entries are only observed once written
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/vpu_cmd_queue.sv
`default_nettype none
// =====================================================================
// Module   : vpu_cmd_queue
// Brief    : VPU command queue/dispatcher with opcode filter, barrier
//            handling and in-flight credit limit. Optional performance
//            counters are enabled by defining VPU_CMDQ_PERF_EN.
// Revision : 1.0 - initial release
// =====================================================================
module vpu_cmd_queue
    import vpu_pkg::*;
#(
    parameter int         CMD_W      = 128,
    parameter int         DEPTH      = 8,
    parameter int         MAX_OUT    = 4,
    parameter logic [7:0] VPU_OPCODE = vpu_pkg::VPU_OPCODE,
    parameter logic [7:0] SYNC_SUBOP = vpu_pkg::SYNC_SUBOP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [CMD_W-1:0]             in_cmd,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CMD_W-1:0]             out_cmd,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         out_done,
    output logic [$clog2(DEPTH):0]       count,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         idle,
    output logic                         sync_done,
    output logic                         err_opcode,
`ifdef VPU_CMDQ_PERF_EN
    input  logic                         perf_clr,
    output logic [31:0]                  perf_issued,
    output logic [31:0]                  perf_stall,
    output logic [15:0]                  perf_dropped,
`endif
    output logic                         err_done
);

    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam logic [OW-1:0] c_max_out = OW'(MAX_OUT);
    localparam int c_opc_lo = CMD_W - 8;
    localparam int c_sub_hi = CMD_W - 9;
    localparam int c_sub_lo = CMD_W - 16;

    cmdq_state_t      r_state;
    cmdq_state_t      w_state_nxt;
    logic [OW-1:0]    r_outstanding;
    logic             r_err_opcode;
    logic             r_err_done;

    logic [CMD_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_xfer;
    logic             w_opc_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_head_sync;
    logic             w_out_valid;
    logic             w_dispatch;
    logic             w_retire;

    assign w_xfer      = in_valid && in_ready;
    assign w_opc_ok    = (in_cmd[CMD_W-1:c_opc_lo] == VPU_OPCODE);
    assign w_push      = w_xfer && w_opc_ok;
    assign w_head_sync = (w_head[c_sub_hi:c_sub_lo] == SYNC_SUBOP);
    assign w_dispatch  = w_out_valid && out_ready;
    assign w_pop       = w_dispatch || w_retire;

    vpu_cmd_fifo #(
        .CMD_W (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_data (in_cmd),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ISSUE;
        else     r_state <= w_state_nxt;
    end

    // Barriers never reach vector_unit; they retire here once all work drains
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ISSUE: begin
                if (!w_empty) begin
                    if (w_head_sync) w_state_nxt = WAIT_SYNC;
                    else             w_out_valid = (r_outstanding < c_max_out);
                end
            end
            WAIT_SYNC: begin
                if (r_outstanding == '0) begin
                    w_retire    = !w_empty;
                    w_state_nxt = ISSUE;
                end
            end
            default: w_state_nxt = ISSUE;
        endcase
        if (flush) w_state_nxt = ISSUE;
    end

    // Credit counter survives flush: completions of in-flight work still arrive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_err_done    <= 1'b0;
            r_err_opcode  <= 1'b0;
        end else begin
            r_err_opcode <= w_xfer && !w_opc_ok;
            if (w_dispatch && !out_done) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_dispatch && out_done) begin
                if (r_outstanding == '0) r_err_done    <= 1'b1;
                else                     r_outstanding <= r_outstanding - 1'b1;
            end
        end
    end

    assign in_ready    = !w_full && !flush;
    assign out_cmd     = w_empty ? '0 : w_head;
    assign out_valid   = w_out_valid;
    assign outstanding = r_outstanding;
    assign idle        = w_empty && (r_outstanding == '0) && (r_state == ISSUE);
    assign sync_done   = w_retire;
    assign err_opcode  = r_err_opcode;
    assign err_done    = r_err_done;

`ifdef VPU_CMDQ_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_dropped;
    logic        w_stall;

    assign w_stall = (r_state == WAIT_SYNC) || ((r_state == ISSUE) && !w_empty && !w_out_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_issued  <= '0;
            r_perf_stall   <= '0;
            r_perf_dropped <= '0;
        end else if (perf_clr) begin
            r_perf_issued  <= '0;
            r_perf_stall   <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_dispatch && !(&r_perf_issued))          r_perf_issued  <= r_perf_issued + 1'b1;
            if (w_stall && !(&r_perf_stall))              r_perf_stall   <= r_perf_stall + 1'b1;
            if (w_xfer && !w_opc_ok && !(&r_perf_dropped)) r_perf_dropped <= r_perf_dropped + 1'b1;
        end
    end

    assign perf_issued  = r_perf_issued;
    assign perf_stall   = r_perf_stall;
    assign perf_dropped = r_perf_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vpu_cmd_queue.sv
`default_nettype none
// =====================================================================
// Module   : tb_vpu_cmd_queue
// Brief    : Self-checking bench for vpu_cmd_queue against a queue-based
//            reference model, directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// =====================================================================
module tb_vpu_cmd_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [127:0] in_cmd = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_done = 1'b0;
    logic         in_ready, out_valid, idle, sync_done, err_opcode, err_done;
    logic [127:0] out_cmd;
    logic [3:0]   count;
    logic [2:0]   outstanding;

    vpu_cmd_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_cmd(in_cmd), .in_valid(in_valid),
        .in_ready(in_ready), .out_cmd(out_cmd), .out_valid(out_valid), .out_ready(out_ready),
        .out_done(out_done), .count(count), .outstanding(outstanding), .idle(idle),
        .sync_done(sync_done), .err_opcode(err_opcode), .err_done(err_done)
    );

    always #5 clk = ~clk;

    // Reference model: command list, in-flight count, barrier-wait flag
    logic [127:0] q[$];
    int           m_out;
    bit           m_wait, m_err_opc, m_err_done, auto_done;
    bit [1:0]     dp;
    int           e_count, e_out;
    logic [127:0] e_cmd;
    bit           e_valid, e_in_ready, e_idle, e_sync;
    int           n_vec = 0;
    int           n_err = 0;

    function automatic logic [127:0] mk(input logic [7:0] opc, input logic [7:0] sub);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[127:120] = opc;
        r[119:112] = sub;
        return r;
    endfunction

    function automatic void calc();
        e_count    = q.size();
        e_out      = m_out;
        e_cmd      = (q.size() > 0) ? q[0] : '0;
        e_valid    = !m_wait && q.size() > 0 && q[0][119:112] != 8'hFF && m_out < 4;
        e_in_ready = q.size() < 8 && !flush;
        e_idle     = q.size() == 0 && m_out == 0 && !m_wait;
        e_sync     = m_wait && m_out == 0 && q.size() > 0;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_out = 0; m_wait = 0; m_err_opc = 0; m_err_done = 0; dp = '0;
    endfunction

    // Advance one clock from a falling edge to the next, updating the model
    task automatic tick();
        bit disp, retire, xfer, bad, nwait;
        calc();
        disp   = e_valid && out_ready;
        retire = e_sync;
        xfer   = in_valid && e_in_ready;
        bad    = xfer && in_cmd[127:120] != 8'h02;
        @(posedge clk);
        nwait = m_wait;
        if (!m_wait && q.size() > 0 && q[0][119:112] == 8'hFF) nwait = 1;
        else if (m_wait && m_out == 0) nwait = 0;
        if (flush) nwait = 0;
        if (disp || retire) void'(q.pop_front());
        if (xfer && !bad) q.push_back(in_cmd);
        if (flush) q.delete();
        if (disp && !out_done) m_out++;
        else if (!disp && out_done) begin
            if (m_out == 0) m_err_done = 1;
            else m_out--;
        end
        m_err_opc = bad;
        m_wait = nwait;
        dp = auto_done ? {dp[0], disp} : 2'b00;
        @(negedge clk);
        if (auto_done) out_done = dp[1];
        calc();
    endtask

    task automatic drain();
        in_valid = 0; flush = 0; out_ready = 1; auto_done = 0;
        for (int i = 0; i < 80; i++) begin
            out_done = (m_out > 0);
            tick();
            if (e_idle) break;
        end
        out_done = 0;
        calc();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_vec++; if (out_cmd !== 128'd0) begin n_err++; $display("FAIL rst_out_cmd got %h exp 0", out_cmd); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b exp 1", idle); end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
        n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
        n_vec++; if ({sync_done, err_opcode, err_done} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b exp 000", {sync_done, err_opcode, err_done}); end
        rst = 0;
        model_reset();
        calc();
    endtask

    task automatic test_order();
        logic [7:0] got[$];
        int peak = 0;
        logic [23:0] seq;
        out_ready = 1; auto_done = 1;
        for (int i = 0; i < 3; i++) begin
            in_cmd = mk(8'h02, 8'h30 + 8'(i)); in_valid = 1;
            if (out_valid) got.push_back(out_cmd[119:112]);
            tick();
            if (int'(outstanding) > peak) peak = int'(outstanding);
        end
        in_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) got.push_back(out_cmd[119:112]);
            tick();
            if (int'(outstanding) > peak) peak = int'(outstanding);
            if (e_idle) break;
        end
        auto_done = 0; out_done = 0;
        seq = (got.size() == 3) ? {got[0], got[1], got[2]} : 24'hEEEEEE;
        n_vec++; if (seq !== 24'h303132) begin n_err++; $display("FAIL order_seq got %h (n=%0d) exp 303132", seq, got.size()); end
        n_vec++; if (peak > 3 || peak < 1) begin n_err++; $display("FAIL order_peak got %0d exp 1..3", peak); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL order_idle got %b exp 1", idle); end
    endtask

    task automatic test_bad_opcode();
        in_cmd = mk(8'h05, 8'h30); in_valid = 1; out_ready = 1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL badop_in_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        n_vec++; if (err_opcode !== 1'b1) begin n_err++; $display("FAIL badop_pulse got %b exp 1", err_opcode); end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL badop_count got %0d exp 0", count); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL badop_out_valid got %b exp 0", out_valid); end
        tick();
        n_vec++; if (err_opcode !== 1'b0) begin n_err++; $display("FAIL badop_once got %b exp 0", err_opcode); end
    endtask

    task automatic test_full();
        logic [127:0] cmds[8];
        out_ready = 0; auto_done = 1;
        for (int i = 0; i < 8; i++) begin
            cmds[i] = mk(8'h02, 8'(8'h40 + i)); in_cmd = cmds[i]; in_valid = 1;
            tick();
        end
        in_valid = 0;
        n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count got %0d exp 8", count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        n_vec++; if (out_cmd !== cmds[0] || out_valid !== 1'b1) begin n_err++; $display("FAIL full_head got %h/%b exp %h/1", out_cmd, out_valid, cmds[0]); end
        tick();
        n_vec++; if (out_cmd !== cmds[0]) begin n_err++; $display("FAIL full_hold got %h exp %h", out_cmd, cmds[0]); end
        out_ready = 1;
        tick();
        n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL full_pop got %0d exp 7", count); end
        in_cmd = mk(8'h02, 8'h50); in_valid = 1;
        tick();
        in_valid = 0;
        n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL full_pushpop_count got %0d exp 7", count); end
        n_vec++; if (out_cmd !== cmds[2]) begin n_err++; $display("FAIL full_pushpop_head got %h exp %h", out_cmd, cmds[2]); end
        drain();
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL full_drain_idle got %b exp 1", idle); end
    endtask

    task automatic test_credit();
        int nd = 0;
        out_ready = 1; auto_done = 0; out_done = 0;
        for (int i = 0; i < 6; i++) begin
            in_cmd = mk(8'h02, 8'(8'h60 + i)); in_valid = 1;
            if (out_valid) nd++;
            tick();
        end
        in_valid = 0;
        repeat (4) begin if (out_valid) nd++; tick(); end
        n_vec++; if (nd !== 4) begin n_err++; $display("FAIL credit_disp got %0d exp 4", nd); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL credit_valid got %b exp 0", out_valid); end
        n_vec++; if (outstanding !== 3'd4 || count !== 4'd2) begin n_err++; $display("FAIL credit_state got out=%0d cnt=%0d exp 4/2", outstanding, count); end
        out_done = 1;
        tick();
        out_done = 0;
        repeat (4) begin if (out_valid) nd++; tick(); end
        n_vec++; if (nd !== 5) begin n_err++; $display("FAIL credit_fifth got %0d exp 5", nd); end
        drain();
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL credit_idle got %b exp 1", idle); end
    endtask

    task automatic test_sync();
        logic [7:0] got[$];
        logic [7:0] subs[3];
        int nsd = 0;
        int nbad = 0;
        subs[0] = 8'h10; subs[1] = 8'hFF; subs[2] = 8'h20;
        out_ready = 1; auto_done = 0; out_done = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) begin in_cmd = mk(8'h02, subs[i]); in_valid = 1; end
            else in_valid = 0;
            if (out_valid) begin got.push_back(out_cmd[119:112]); if (out_cmd[119:112] == 8'hFF) nbad++; end
            if (sync_done) nsd++;
            tick();
        end
        n_vec++; if (got.size() != 1 || nsd != 0) begin n_err++; $display("FAIL sync_block got disp=%0d sd=%0d exp 1/0", got.size(), nsd); end
        out_done = 1;
        tick();
        out_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin got.push_back(out_cmd[119:112]); if (out_cmd[119:112] == 8'hFF) nbad++; end
            if (sync_done) nsd++;
            tick();
        end
        n_vec++; if (got.size() != 2 || got[got.size()-1] !== 8'h20) begin n_err++; $display("FAIL sync_release got n=%0d last=%h exp 2/20", got.size(), got[got.size()-1]); end
        n_vec++; if (nsd !== 1) begin n_err++; $display("FAIL sync_done_count got %0d exp 1", nsd); end
        n_vec++; if (nbad !== 0) begin n_err++; $display("FAIL sync_leak got %0d exp 0", nbad); end
        drain();
    endtask

    task automatic test_err_flush();
        out_done = 1;
        tick();
        out_done = 0;
        n_vec++; if (err_done !== 1'b1) begin n_err++; $display("FAIL errdone_set got %b exp 1", err_done); end
        tick();
        n_vec++; if (err_done !== 1'b1) begin n_err++; $display("FAIL errdone_sticky got %b exp 1", err_done); end
        out_ready = 1; in_cmd = mk(8'h02, 8'h70); in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin in_cmd = mk(8'h02, 8'(8'h71 + i)); in_valid = 1; tick(); end
        in_valid = 0;
        n_vec++; if (count !== 4'd5 || outstanding !== 3'd1) begin n_err++; $display("FAIL flush_pre got cnt=%0d out=%0d exp 5/1", count, outstanding); end
        flush = 1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        tick();
        flush = 0;
        n_vec++; if (count !== 4'd0 || outstanding !== 3'd1) begin n_err++; $display("FAIL flush_post got cnt=%0d out=%0d exp 0/1", count, outstanding); end
        drain();
        n_vec++; if (idle !== 1'b1 || outstanding !== 3'd0) begin n_err++; $display("FAIL flush_idle got %b/%0d exp 1/0", idle, outstanding); end
    endtask

    task automatic test_random();
        auto_done = 0;
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_cmd    = mk(($urandom_range(0, 9) == 0) ? 8'h05 : 8'h02,
                           ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            out_done  = (m_out > 0) && ($urandom_range(0, 9) < 4);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
            n_vec++; if (out_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid @%0t got %b exp %b", $time, out_valid, e_valid); end
            n_vec++; if (out_cmd !== e_cmd) begin n_err++; $display("FAIL rnd_cmd @%0t got %h exp %h", $time, out_cmd, e_cmd); end
            n_vec++; if (in_ready !== e_in_ready) begin n_err++; $display("FAIL rnd_in_ready @%0t got %b exp %b", $time, in_ready, e_in_ready); end
            n_vec++; if (count !== 4'(e_count)) begin n_err++; $display("FAIL rnd_count @%0t got %0d exp %0d", $time, count, e_count); end
            n_vec++; if (outstanding !== 3'(e_out)) begin n_err++; $display("FAIL rnd_outstanding @%0t got %0d exp %0d", $time, outstanding, e_out); end
            n_vec++; if (idle !== e_idle) begin n_err++; $display("FAIL rnd_idle @%0t got %b exp %b", $time, idle, e_idle); end
            n_vec++; if (sync_done !== e_sync) begin n_err++; $display("FAIL rnd_sync_done @%0t got %b exp %b", $time, sync_done, e_sync); end
            n_vec++; if (err_opcode !== m_err_opc) begin n_err++; $display("FAIL rnd_err_opcode @%0t got %b exp %b", $time, err_opcode, m_err_opc); end
            n_vec++; if (err_done !== m_err_done) begin n_err++; $display("FAIL rnd_err_done @%0t got %b exp %b", $time, err_done, m_err_done); end
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin in_cmd = mk(8'h02, 8'(8'h80 + i)); in_valid = 1; tick(); end
        in_valid = 0; out_ready = 1;
        tick();
        #2 rst = 1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_cmd !== 128'd0) begin n_err++; $display("FAIL arst_out got %b/%h exp 0/0", out_valid, out_cmd); end
        n_vec++; if (count !== 4'd0 || outstanding !== 3'd0) begin n_err++; $display("FAIL arst_counts got %0d/%0d exp 0/0", count, outstanding); end
        n_vec++; if (in_ready !== 1'b1 || idle !== 1'b1) begin n_err++; $display("FAIL arst_ready_idle got %b/%b exp 1/1", in_ready, idle); end
        n_vec++; if (err_done !== 1'b0) begin n_err++; $display("FAIL arst_err_done got %b exp 0", err_done); end
        @(negedge clk);
        rst = 0;
        model_reset();
        calc();
        out_done = 1;
        tick();
        out_done = 0;
        n_vec++; if (err_done !== m_err_done || err_done !== 1'b1) begin n_err++; $display("FAIL arst_late_done got %b exp 1", err_done); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_order();
        test_bad_opcode();
        test_full();
        test_credit();
        test_sync();
        test_err_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
